// File: rtl/char_link_pkg.sv
// -----------------------------------------------------------------------------
// char_link_pkg
//   Settings shared by the UDP character-link receive path. It holds:
//     - default link parameters: the header magic, the number of words per
//       chunk and the number of chunks per frame;
//     - the receive FSM state encoding;
//     - a saturating 8-bit increment used by the drop counter.
//   WORDS_PER_CHUNK_DEF * CHUNKS_DEF must equal the 2048-word, 11-bit write
//   address span of the downstream character RAM.
// -----------------------------------------------------------------------------
package char_link_pkg;

  localparam logic [15:0] MAGIC_DEF           = 16'hA55A;
  localparam int          WORDS_PER_CHUNK_DEF = 64;
  localparam int          CHUNKS_DEF          = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // waiting for the first byte of a packet
    ST_HDR  = 3'd1,  // collecting header bytes 1..3
    ST_DATA = 3'd2,  // packing payload bytes into words
    ST_PAD  = 3'd3,  // emitting zero words up to a full chunk
    ST_SKIP = 3'd4   // discarding bytes until the end of the packet
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_packer_32.sv
// -----------------------------------------------------------------------------
// byte_packer_32
//   Packs a byte stream into big-endian 32-bit words. The first byte of a word
//   goes to [31:24]. A word is presented on the same cycle as the byte that
//   completes it: either the 4th byte, or any byte pushed with flush_i. On a
//   flush the unfilled low bytes are zero.
//
//   Ports
//     udp_clk       clock
//     rstn          asynchronous active-low reset
//     clear_i       discard any partially packed bytes
//     push_i        data_i holds a byte to pack this cycle
//     flush_i       this pushed byte ends the stream; emit the partial word
//     data_i        byte to pack
//     word_valid_o  word_o is complete this cycle (combinational)
//     word_o        packed word, with the current byte merged in
// -----------------------------------------------------------------------------
module byte_packer_32 (
  input  logic        udp_clk,
  input  logic        rstn,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        flush_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] acc_q, acc_d;   // bytes already packed, left-aligned
  logic [1:0]  cnt_q, cnt_d;   // number of bytes held in acc_q
  logic [4:0]  shamt;
  logic [31:0] merged;

  // NOTE: every signal written in this block gets a default value at the top.
  // If some path left a signal unassigned, synthesis would infer a latch.
  always_comb begin
    shamt        = 5'd24 - {cnt_q, 3'b000};
    merged       = {acc_q, 8'h00} | ({24'h00_0000, data_i} << shamt);
    word_valid_o = push_i && (flush_i || (cnt_q == 2'd3));
    word_o       = merged;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    if (clear_i || word_valid_o) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      acc_d = merged[31:8];
      cnt_d = cnt_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the clock edge. This keeps the order of
  // statements in the block from affecting the result.
  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/udp_char_rx.sv
// -----------------------------------------------------------------------------
// udp_char_rx
//   Receives character-RAM chunks carried in UDP payloads and turns each
//   accepted packet into exactly WORDS_PER_CHUNK word writes. This keeps the
//   downstream 11-bit write address aligned.
//
//   Packet layout: MAGIC[15:8], MAGIC[7:0], chunk index, reserved, data bytes.
//   A packet is accepted only if its magic matches, its index equals the
//   expected chunk, and it does not end inside the header. A short payload is
//   zero-filled and then padded with zero words. Surplus bytes are ignored.
//
//   Ports
//     udp_clk       clock
//     rstn          asynchronous active-low reset
//     udp_rx_valid  payload byte strobe
//     udp_rx_data   payload byte
//     udp_rx_last   final byte of the packet (qualified by udp_rx_valid)
//     rec_en        one-cycle word write strobe
//     rec_data      packed word, valid with rec_en
//     busy          padding in progress; bytes offered now are lost
//     frame_done    pulses with the final write of chunk CHUNKS-1
//     drop_cnt      rejected packets, saturating at 255
//     overrun       sticky: a byte arrived while busy
// -----------------------------------------------------------------------------
module udp_char_rx
  import char_link_pkg::*;
#(
  parameter logic [15:0] MAGIC           = MAGIC_DEF,
  parameter int          WORDS_PER_CHUNK = WORDS_PER_CHUNK_DEF,
  parameter int          CHUNKS          = CHUNKS_DEF
) (
  input  logic        udp_clk,
  input  logic        rstn,
  input  logic        udp_rx_valid,
  input  logic [7:0]  udp_rx_data,
  input  logic        udp_rx_last,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt,
  output logic        overrun
);

  localparam int WCW = $clog2(WORDS_PER_CHUNK + 1);
  localparam int ECW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [WCW-1:0] WORDS_FULL = WCW'(WORDS_PER_CHUNK);
  localparam logic [ECW-1:0] CHUNK_LAST = ECW'(CHUNKS - 1);

  rx_state_e       state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      hdr0_q, hdr0_d;
  logic [7:0]      hdr1_q, hdr1_d;
  logic [7:0]      hdr2_q, hdr2_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [ECW-1:0]  exp_chunk_q, exp_chunk_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            overrun_q, overrun_d;
  logic            rec_en_q, rec_en_d;
  logic [31:0]     rec_data_q, rec_data_d;
  logic            frame_done_q, frame_done_d;

  logic            pk_clear, pk_push, pk_flush, pk_word_valid;
  logic [31:0]     pk_word;

  logic [WCW-1:0]  word_cnt_inc;
  logic [ECW-1:0]  exp_chunk_inc;
  logic            hdr_ok;
  logic            chunk_full;

  byte_packer_32 u_packer (
    .udp_clk      (udp_clk),
    .rstn         (rstn),
    .clear_i      (pk_clear),
    .push_i       (pk_push),
    .flush_i      (pk_flush),
    .data_i       (udp_rx_data),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  // The header is judged when byte 3 arrives. Bytes 0..2 are already
  // registered by then, and the reserved byte 3 is never stored.
  assign hdr_ok        = (hdr0_q == MAGIC[15:8]) && (hdr1_q == MAGIC[7:0]) &&
                         (hdr2_q == 8'(exp_chunk_q));
  assign word_cnt_inc  = word_cnt_q + WCW'(1);
  assign chunk_full    = (word_cnt_inc == WORDS_FULL);
  assign exp_chunk_inc = (exp_chunk_q == CHUNK_LAST) ? '0 : exp_chunk_q + ECW'(1);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    hdr0_d       = hdr0_q;
    hdr1_d       = hdr1_q;
    hdr2_d       = hdr2_q;
    word_cnt_d   = word_cnt_q;
    exp_chunk_d  = exp_chunk_q;
    drop_cnt_d   = drop_cnt_q;
    overrun_d    = overrun_q;
    rec_en_d     = 1'b0;
    rec_data_d   = '0;
    frame_done_d = 1'b0;
    pk_clear     = 1'b0;
    pk_push      = 1'b0;
    pk_flush     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (udp_rx_valid) begin
          hdr0_d = udp_rx_data;
          if (udp_rx_last) begin
            // A single-byte packet ends inside the header.
            drop_cnt_d = sat_inc8(drop_cnt_q);
          end else begin
            byte_idx_d = 2'd1;
            state_d    = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (udp_rx_valid) begin
          if (byte_idx_q == 2'd1) hdr1_d = udp_rx_data;
          if (byte_idx_q == 2'd2) hdr2_d = udp_rx_data;
          if (udp_rx_last) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
            byte_idx_d = 2'd0;
            state_d    = ST_IDLE;
          end else if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            if (hdr_ok) begin
              word_cnt_d = '0;
              pk_clear   = 1'b1;
              state_d    = ST_DATA;
            end else begin
              drop_cnt_d = sat_inc8(drop_cnt_q);
              state_d    = ST_SKIP;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      ST_DATA: begin
        if (udp_rx_valid) begin
          pk_push  = 1'b1;
          pk_flush = udp_rx_last;
          // Either the 4th byte or the last byte of the packet yields a word.
          if (pk_word_valid) begin
            rec_en_d   = 1'b1;
            rec_data_d = pk_word;
            word_cnt_d = word_cnt_inc;
            if (chunk_full) begin
              exp_chunk_d  = exp_chunk_inc;
              frame_done_d = (exp_chunk_q == CHUNK_LAST);
              state_d      = udp_rx_last ? ST_IDLE : ST_SKIP;
            end else if (udp_rx_last) begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        // Bytes offered here are lost. They are flagged but never consumed.
        if (udp_rx_valid) overrun_d = 1'b1;
        rec_en_d   = 1'b1;
        word_cnt_d = word_cnt_inc;
        if (chunk_full) begin
          exp_chunk_d  = exp_chunk_inc;
          frame_done_d = (exp_chunk_q == CHUNK_LAST);
          state_d      = ST_IDLE;
        end
      end

      ST_SKIP: begin
        if (udp_rx_valid && udp_rx_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      hdr0_q       <= '0;
      hdr1_q       <= '0;
      hdr2_q       <= '0;
      word_cnt_q   <= '0;
      exp_chunk_q  <= '0;
      drop_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      rec_en_q     <= 1'b0;
      rec_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      hdr0_q       <= hdr0_d;
      hdr1_q       <= hdr1_d;
      hdr2_q       <= hdr2_d;
      word_cnt_q   <= word_cnt_d;
      exp_chunk_q  <= exp_chunk_d;
      drop_cnt_q   <= drop_cnt_d;
      overrun_q    <= overrun_d;
      rec_en_q     <= rec_en_d;
      rec_data_q   <= rec_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rec_en     = rec_en_q;
  assign rec_data   = rec_data_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == ST_PAD);

endmodule

// File: tb/tb_udp_char_rx.sv
// -----------------------------------------------------------------------------
// tb_udp_char_rx
//   Self-checking bench for udp_char_rx. Each packet is run through a
//   packet-level reference model. The model decides accept or drop, and for an
//   accepted packet it pushes the expected words into a scoreboard queue. A
//   monitor pops and compares whenever the DUT presents rec_en.
// -----------------------------------------------------------------------------
module tb_udp_char_rx;

  localparam int WPC = 64;
  localparam int NCH = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic        fd;
  } exp_t;

  logic        udp_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        udp_rx_valid = 1'b0;
  logic [7:0]  udp_rx_data = 8'h00;
  logic        udp_rx_last = 1'b0;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;
  logic        overrun;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_words = 0;
  int   n_fd = 0;
  int   m_exp = 0;
  int   m_drop = 0;

  udp_char_rx dut (
    .udp_clk      (udp_clk),
    .rstn         (rstn),
    .udp_rx_valid (udp_rx_valid),
    .udp_rx_data  (udp_rx_data),
    .udp_rx_last  (udp_rx_last),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .drop_cnt     (drop_cnt),
    .overrun      (overrun)
  );

  always #5 udp_clk = ~udp_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model at packet granularity. The data area is the payload
  // truncated or zero-extended to WPC*4 bytes.
  function automatic void model_pkt(input bq_t pkt);
    logic [31:0] w;
    int          k;
    if (pkt.size() < 5 || pkt[0] != 8'hA5 || pkt[1] != 8'h5A || pkt[2] != 8'(m_exp)) begin
      m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    end else begin
      for (int i = 0; i < WPC; i++) begin
        w = '0;
        for (int b = 0; b < 4; b++) begin
          k = 4 + 4 * i + b;
          w = {w[23:0], (k < pkt.size()) ? pkt[k] : 8'h00};
        end
        sb.push_back('{data: w, fd: (i == WPC - 1) && (m_exp == NCH - 1)});
      end
      m_exp = (m_exp + 1) % NCH;
    end
  endfunction

  function automatic bq_t mk_hdr(input int idx);
    bq_t q;
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    q.push_back(8'(idx));
    q.push_back(8'($urandom_range(255, 0)));
    return q;
  endfunction

  task automatic send_bytes(input bq_t pkt, input int max_gap, input bit with_last);
    int g;
    for (int i = 0; i < pkt.size(); i++) begin
      udp_rx_valid = 1'b1;
      udp_rx_data  = pkt[i];
      udp_rx_last  = with_last && (i == pkt.size() - 1);
      @(posedge udp_clk); #1;
      udp_rx_valid = 1'b0;
      udp_rx_last  = 1'b0;
      if (max_gap > 0 && i != pkt.size() - 1) begin
        g = $urandom_range(max_gap, 0);
        repeat (g) begin @(posedge udp_clk); #1; end
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(posedge udp_clk); #1;
      t++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_pkt(input bq_t pkt, input int max_gap);
    model_pkt(pkt);
    send_bytes(pkt, max_gap, 1'b1);
    wait_idle();
  endtask

  task automatic reset_and_check();
    @(negedge udp_clk); #1;
    rstn = 1'b0;
    #2;
    check("rst_rec_en", {31'd0, rec_en}, 32'd0);
    check("rst_rec_data", rec_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    m_exp  = 0;
    m_drop = 0;
    repeat (2) @(negedge udp_clk);
    rstn = 1'b1;
    @(posedge udp_clk); #1;
  endtask

  // Monitor: every output word is matched against the scoreboard.
  always @(negedge udp_clk) begin
    if (rstn) begin
      if (busy) check("pad_rec_en", {31'd0, rec_en}, 32'd1);
      if (rec_en) begin
        n_words++;
        if (frame_done) n_fd++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", rec_data);
        end else begin
          mon_e = sb.pop_front();
          check("rec_data", rec_data, mon_e.data);
          check("frame_done", {31'd0, frame_done}, {31'd0, mon_e.fd});
        end
      end else begin
        check("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  initial begin
    bq_t pkt;
    int  kind, len, base_w, base_fd;

    repeat (2) @(posedge udp_clk);
    reset_and_check();

    // Full 256-byte chunk 0.
    pkt = mk_hdr(0);
    for (int i = 0; i < 256; i++) pkt.push_back(8'(i));
    send_pkt(pkt, 0);

    // Short chunk: partial word, then padding while busy.
    pkt = mk_hdr(m_exp);
    for (int i = 1; i <= 10; i++) pkt.push_back(8'(i));
    model_pkt(pkt);
    send_bytes(pkt, 0, 1'b1);
    check("busy_in_pad", {31'd0, busy}, 32'd1);
    wait_idle();

    // Bad magic: rejected, one drop.
    pkt = {8'h12, 8'h34, 8'h00, 8'h00, 8'h55};
    send_pkt(pkt, 0);
    check("drop_cnt_one", {24'd0, drop_cnt}, m_drop);

    // Random mix of good and bad packets.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(9, 0);
      len  = $urandom_range(300, 1);
      pkt  = mk_hdr(m_exp);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(255, 0)));
      case (kind)
        0: pkt[0] = pkt[0] ^ 8'h10;
        1: pkt[1] = pkt[1] ^ 8'h01;
        2: pkt[2] = 8'((m_exp + $urandom_range(NCH - 1, 1)) % NCH);
        3: pkt[2] = 8'(m_exp) | 8'h20;
        4: begin
          len = $urandom_range(4, 1);
          while (pkt.size() > len) void'(pkt.pop_back());
        end
        default: ;
      endcase
      send_pkt(pkt, 2);
      check("drop_cnt_rand", {24'd0, drop_cnt}, m_drop);
    end

    // A byte offered during padding sets overrun and changes nothing else.
    check("overrun_clear", {31'd0, overrun}, 32'd0);
    pkt = mk_hdr(m_exp);
    for (int i = 0; i < 10; i++) pkt.push_back(8'($urandom_range(255, 0)));
    model_pkt(pkt);
    send_bytes(pkt, 0, 1'b1);
    repeat (3) begin @(posedge udp_clk); #1; end
    check("busy_before_overrun", {31'd0, busy}, 32'd1);
    udp_rx_valid = 1'b1;
    udp_rx_data  = 8'h77;
    @(posedge udp_clk); #1;
    udp_rx_valid = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle();

    // Drop counter saturation.
    for (int n = 0; n < 300; n++) begin
      pkt = {8'h12, 8'h34, 8'h00, 8'h00, 8'h99};
      send_pkt(pkt, 0);
    end
    check("drop_cnt_sat", {24'd0, drop_cnt}, m_drop);

    // Whole frame: chunks 0..NCH-1, then an out-of-order index.
    reset_and_check();
    base_w  = n_words;
    base_fd = n_fd;
    for (int c = 0; c < NCH; c++) begin
      pkt = mk_hdr(c);
      len = $urandom_range(270, 1);
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(255, 0)));
      send_pkt(pkt, 1);
    end
    repeat (3) begin @(posedge udp_clk); #1; end
    check("frame_words", n_words - base_w, NCH * WPC);
    check("frame_done_count", n_fd - base_fd, 1);
    pkt = mk_hdr(5);
    for (int i = 0; i < 8; i++) pkt.push_back(8'(i));
    send_pkt(pkt, 0);
    check("drop_after_frame", {24'd0, drop_cnt}, m_drop);

    // Reset after 20 words abandons the packet. Chunk 0 is accepted afterwards.
    pkt = mk_hdr(0);
    for (int i = 0; i < 80; i++) pkt.push_back(8'($urandom_range(255, 0)));
    for (int w = 0; w < 20; w++)
      sb.push_back('{data: {pkt[4+4*w], pkt[5+4*w], pkt[6+4*w], pkt[7+4*w]}, fd: 1'b0});
    send_bytes(pkt, 0, 1'b0);
    reset_and_check();
    pkt = mk_hdr(0);
    for (int i = 0; i < 100; i++) pkt.push_back(8'($urandom_range(255, 0)));
    send_pkt(pkt, 0);
    check("drop_after_reset", {24'd0, drop_cnt}, m_drop);

    for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(posedge udp_clk); #1; end
    repeat (3) begin @(posedge udp_clk); #1; end
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_char_rx.md
UDP_CHAR_RX -- requirements
Module: udp_char_rx

Interface
REQ-001 SHALL have parameter MAGIC, default 16'hA55A, meaning the required first two header bytes.
REQ-002 SHALL have parameter WORDS_PER_CHUNK, default 64, meaning the 32-bit words emitted per accepted packet.
REQ-003 SHALL have parameter CHUNKS, default 32, meaning the chunks per frame; WORDS_PER_CHUNK*CHUNKS SHALL equal 2048, the downstream 11-bit write-address span.
REQ-004 udp_clk  in  1  clock; all logic in this domain.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 udp_rx_valid  in  1  payload byte strobe, at most one byte per cycle.
REQ-007 udp_rx_data  in  8  payload byte.
REQ-008 udp_rx_last  in  1  qualifies the final byte of a packet; valid only with udp_rx_valid.
REQ-009 rec_en  out  1  one-cycle word write strobe to the character RAM stage.
REQ-010 rec_data  out  32  packed word, valid when rec_en=1.
REQ-011 busy  out  1  high in PAD; bytes offered while busy are lost.
REQ-012 frame_done  out  1  one-cycle pulse when chunk CHUNKS-1 completes.
REQ-013 drop_cnt  out  8  count of rejected packets, saturating at 255.
REQ-014 overrun  out  1  sticky flag, set when a byte arrives while busy.

Function
REQ-015 Packet format SHALL be: byte0=MAGIC[15:8], byte1=MAGIC[7:0], byte2=chunk index (bits[7:5] zero), byte3=reserved (ignored), then data bytes.
REQ-016 FSM states SHALL be IDLE, HDR, DATA, PAD and SKIP.
REQ-017 IDLE SHALL move to HDR on the first valid byte and capture it as byte0.
REQ-018 HDR SHALL collect bytes 0-3; if all header checks pass on byte3 without last, it SHALL enter DATA.
REQ-019 A header SHALL be rejected on magic mismatch, chunk index != expected chunk counter (exp_chunk), or last within bytes 0-3.
REQ-020 On rejection: drop_cnt+1; next state SKIP, or IDLE if last has already been seen; nothing emitted.
REQ-021 DATA SHALL pack bytes big-endian (first byte to [31:24]); rec_en SHALL pulse exactly one cycle after the 4th byte of each word.
REQ-022 word_cnt SHALL count emitted words 0..WORDS_PER_CHUNK.
REQ-023 If last arrives mid-word in DATA, the partial word SHALL be emitted with unfilled low bytes zero, then the FSM SHALL enter PAD if word_cnt < WORDS_PER_CHUNK.
REQ-024 If last arrives on a word boundary with word_cnt < WORDS_PER_CHUNK, the FSM SHALL enter PAD.
REQ-025 PAD SHALL emit rec_data=0 with rec_en=1 every cycle until word_cnt = WORDS_PER_CHUNK.
REQ-026 When word_cnt reaches WORDS_PER_CHUNK, exp_chunk SHALL increment modulo CHUNKS; next state SHALL be IDLE if last was seen, else SKIP (surplus bytes ignored, not counted as a drop).
REQ-027 frame_done SHALL pulse in the same cycle as the final rec_en of chunk CHUNKS-1.
REQ-028 SKIP SHALL discard bytes until last, then enter IDLE.
REQ-029 Every accepted packet SHALL produce exactly WORDS_PER_CHUNK rec_en pulses, and a rejected packet SHALL produce zero, so downstream address alignment is preserved.
REQ-030 A valid byte in PAD SHALL set overrun and SHALL otherwise be ignored.

Reset
REQ-031 Asserting rstn low SHALL force state=IDLE, rec_en=0, rec_data=0, busy=0, frame_done=0, drop_cnt=0, overrun=0, exp_chunk=0, word_cnt=0 and the byte index to 0.
REQ-032 Reset mid-packet SHALL abandon the packet with no further rec_en; the downstream stage is reset by the same rstn.

Structure
REQ-033 MAGIC, WORDS_PER_CHUNK, CHUNKS and the FSM state encoding SHALL live in a shared package, char_link_pkg.
REQ-034 One sub-module, byte_packer_32 (byte-to-word packing, zero-fill flush), is natural; the FSM and counters SHALL stay in udp_char_rx.

Verification
REQ-035 Valid packet A5 5A 00 00 + 256 bytes 00..FF -> 64 rec_en pulses, first rec_data 32'h00010203, last 32'hFCFDFEFF, exp_chunk=1.
REQ-036 Chunk 0 with only 10 data bytes 01..0A -> words 32'h01020304, 32'h05060708, 32'h090A0000, then 61 zero words on consecutive cycles with busy high.
REQ-037 Header 12 34 00 00 -> no rec_en, drop_cnt=1, exp_chunk unchanged; repeated 300 times -> drop_cnt=255.
REQ-038 Chunk indices 0..31 in order -> 2048 total rec_en, frame_done pulses once on the 2048th, exp_chunk=0; then index 5 -> dropped.
REQ-039 Byte offered during PAD -> overrun=1, pad count unaffected, still 64 words.
REQ-040 rstn low after 20 data words -> outputs at reset values next edge; a subsequent chunk 0 is accepted normally.
